rx_pkt_fifo_ctrl: RTL
=====================

// Module: rx_pkt_fifo_ctrl
// PURPOSE
//  Single-clock packet FIFO controller for the MAC RX path. It drives one duram
//  instance: port A writes, port B reads. The parent ties both duram clocks to Clk
//  and ties wren_b low. Frames are committed only on a good EOP, so errored or
//  overflowed frames are rolled back and never reach the reader.
// PARAMETERS
//  DATA_WIDTH  36  RAM word width; bit DATA_WIDTH-1 stores EOP, the lower bits are payload
//  ADDR_WIDTH  9   RAM address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  Clk           in   1       sole clock
//  Reset         in   1       synchronous, active-high
//  wr_valid      in   1       input word valid; there is no backpressure (MAC cannot stall)
//  wr_data       in   DW-1    input payload
//  wr_eop        in   1       last word of frame; qualified by wr_valid
//  wr_err        in   1       frame bad; sampled only with wr_valid&wr_eop
//  wr_full       out  1       registered: (wr_ptr-rd_ptr)==DEPTH
//  overflow      out  1       1-cycle pulse when a frame is dropped for lack of space
//  drop_cnt      out  16      frames dropped (error or overflow); saturates at 16'hFFFF
//  rd_valid      out  1       committed data available: rd_ptr!=commit_ptr
//  rd_ready      in   1       reader accepts the word when rd_valid&rd_ready
//  rd_data       out  DW-1    ram_q_b[DW-2:0]
//  rd_eop        out  1       ram_q_b[DW-1]
//  frame_cnt     out  AW+1    committed frames not yet fully read
//  ram_address_a out  AW      wr_ptr[AW-1:0]
//  ram_data_a    out  DW      {wr_eop,wr_data}
//  ram_wren_a    out  1       combinational write strobe
//  ram_address_b out  AW      rd_ptr[AW-1:0]
//  ram_q_b       in   DW      duram read data; 0-cycle latency from ram_address_b
// BEHAVIOUR
//  - Pointers wr_ptr, commit_ptr and rd_ptr are AW+1 bits wide. Their MSB is the wrap bit.
//    All arithmetic is modulo 2**(AW+1).
//  - Reset: all pointers 0, state W_IDLE, frame_cnt=0, drop_cnt=0, overflow=0,
//    wr_full=0, rd_valid=0.
//  - Reset mid-frame discards everything, including committed frames.
//  - accept = wr_valid & !full & state!=W_DROP.
//    ram_wren_a = accept. On accept, wr_ptr increments next cycle.
//  - Write FSM:
//    W_IDLE:  accept & !eop -> W_FRAME.
//             accept & eop  -> commit/rollback, stay.
//             wr_valid & full -> overflow drop; go W_DROP if !eop, else stay.
//    W_FRAME: accept & eop  -> commit/rollback -> W_IDLE.
//             wr_valid & full -> overflow drop; go W_DROP, or W_IDLE if eop.
//    W_DROP:  no writes; wr_valid & eop -> W_IDLE.
//  - Commit (eop & !err): commit_ptr <= wr_ptr+1, frame_cnt +1.
//  - Rollback (eop & err): wr_ptr <= commit_ptr, drop_cnt +1.
//  - Overflow drop: wr_ptr <= commit_ptr, drop_cnt +1, overflow=1 for one cycle.
//    The offending word is not written.
//  - Frames longer than DEPTH always overflow. No partial frame is ever visible.
//  - Read: rd_valid depends on registers only. The data is combinational via duram.
//    On rd_valid & rd_ready, rd_ptr increments. If rd_eop, frame_cnt decrements.
//    rd_ready while !rd_valid is ignored.
//  - A commit and an EOP pop in the same cycle leave frame_cnt unchanged.
//  - Commit latency: rd_valid rises the cycle after the EOP write.
//  - The reader never passes commit_ptr, so rollback cannot corrupt read data.
// TESTING
//  1 Good frame: 4 words A0..A3, eop on A3, err=0.
//    -> rd_valid high 1 cycle after A3. Reads A0..A3 with rd_eop on A3.
//    -> frame_cnt 1 then 0. drop_cnt=0.
//  2 Errored frame: 3 words, err=1 at eop.
//    -> rd_valid stays 0, drop_cnt=1.
//    -> A following 2-word good frame reads back exactly, from the old commit address.
//  3 Overflow, AW=4 (DEPTH 16), no reads: 20-word frame.
//    -> overflow pulses on word 17, drop_cnt=1, rd_valid=0.
//    -> The next 3-word frame is delivered intact.
//  4 Concurrency: one frame queued, the reader pops its EOP in the cycle a second frame commits.
//    -> frame_cnt stays 1.
//  5 Reset mid-frame after 2 words, with one committed frame queued.
//    -> All outputs return to reset values. A new frame is delivered correctly.
//  6 Wrap, AW=4: 200 random 1-9 word frames, 10% err, random rd_ready.
//    -> The scoreboard sees only good frames, in order, bit-exact.
//    -> drop_cnt equals injected errors plus overflows.

Source files
------------

// File: rtl/rx_pkt_fifo_ctrl.sv
// RX packet FIFO controller: writes frames into a dual-port RAM, commits them only on a
// good EOP, rolls back errored or overflowed frames, and serves committed words to the reader.
module rx_pkt_fifo_ctrl #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-2:0] wr_data,
  input  logic                  wr_eop,
  input  logic                  wr_err,
  output logic                  wr_full,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-2:0] rd_data,
  output logic                  rd_eop,
  output logic [ADDR_WIDTH:0]   frame_cnt,
  output logic [ADDR_WIDTH-1:0] ram_address_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_wren_a,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_DROP  = 2'd2
  } wstate_e;

  wstate_e       state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  logic full;
  logic accept;
  logic ovf_hit;
  logic commit;
  logic rollback;
  logic pop;
  logic pop_eop;

  // Occupancy counts uncommitted words too, so an oversized frame always runs into full.
  always_comb begin
    full     = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    accept   = wr_valid & ~full & (state_q != W_DROP);
    ovf_hit  = wr_valid & full & (state_q != W_DROP);
    commit   = accept & wr_eop & ~wr_err;
    rollback = accept & wr_eop & wr_err;
    pop      = (rd_ptr_q != commit_ptr_q) & rd_ready;
    pop_eop  = pop & ram_q_b[DATA_WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: begin
        if (accept & ~wr_eop) begin
          state_d = W_FRAME;
        end else if (ovf_hit & ~wr_eop) begin
          state_d = W_DROP;
        end
      end
      W_FRAME: begin
        if (accept & wr_eop) begin
          state_d = W_IDLE;
        end else if (ovf_hit) begin
          state_d = wr_eop ? W_IDLE : W_DROP;
        end
      end
      W_DROP: begin
        if (wr_valid & wr_eop) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = ovf_hit;

    // A discarded frame rewinds the write pointer to the last committed boundary.
    if (rollback | ovf_hit) begin
      wr_ptr_d = commit_ptr_q;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (commit) begin
      commit_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({commit, pop_eop})
      2'b10:   frame_cnt_d = frame_cnt_q + PW'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - PW'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase

    if ((rollback | ovf_hit) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_full       = full;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign rd_valid      = (rd_ptr_q != commit_ptr_q);
  assign rd_data       = ram_q_b[DATA_WIDTH-2:0];
  assign rd_eop        = ram_q_b[DATA_WIDTH-1];
  assign frame_cnt     = frame_cnt_q;
  assign ram_address_a = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_data_a    = {wr_eop, wr_data};
  assign ram_wren_a    = accept;
  assign ram_address_b = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule
